a_trace_capture: RTL and testbench

- Consumer side of the user-clock capture strobe. On each capt_trce strobe during a verification run, it samples the DUT trace vector into a small FIFO.
- The host drains the FIFO through the same 16-bit register read/write interface used by the clock-programming block, one 16-bit slice per read.
- It asserts a hold request toward the clock generator when the FIFO is nearly full, so no trace sample is lost.

---
 rtl/a_trace_capture.sv | 122 ++++++++++++
 tb/tb_a_trace_capture.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/a_trace_capture.sv
// Trace capture FIFO: samples the DUT trace vector on each accepted capture strobe
// and lets the host drain it one 16-bit slice per register read.
module a_trace_capture #(
  parameter int TRACE_W = 64,
  parameter int DEPTH   = 16,
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk_ref,
  input  logic               rst_n,
  input  logic               run_verif_i,
  input  logic               capt_trce_i,
  input  logic [TRACE_W-1:0] trace_i,
  input  logic               r_trace_sel_i,
  input  logic               r_w_i,
  input  logic               r_dv_i,
  input  logic [15:0]        r_q_16data_i,
  output logic [15:0]        r_variable_o,
  output logic               r_dv_trace_o,
  output logic               fifo_empty_o,
  output logic               fifo_full_o,
  output logic               overflow_o,
  output logic               hold_clk_o,
  output logic [CW-1:0]      count_o
);

  localparam int NSLICE = TRACE_W / 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state_q, state_nxt;
  logic [TRACE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [KW-1:0]      slice_q;
  logic [CW-1:0]      count_q, count_nxt;
  logic               overflow_q, full_q, empty_q, hold_q, hold_en_q, hold_en_nxt;
  logic [15:0]        rdata_q, rd_word;
  logic [TRACE_W-1:0] head;
  logic               cap, host_wr, rd_req, clr, push, pop, drop, last_slice;
  logic               unused_wdata;

  function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic [CW-1:0] cnt);
    return {ovf, full, empty, 5'b0, 8'(cnt)};
  endfunction

  assign cap          = capt_trce_i & run_verif_i;
  assign host_wr      = r_trace_sel_i & r_w_i & r_dv_i;
  assign rd_req       = r_trace_sel_i & ~r_w_i & r_dv_i;
  assign clr          = host_wr & r_q_16data_i[0];
  assign unused_wdata = ^r_q_16data_i[15:2];

  // Clear overrides any capture or pop landing in the same cycle.
  assign last_slice = (slice_q == KW'(NSLICE - 1));
  assign push       = cap & ~full_q & ~clr;
  assign drop       = cap & full_q & ~clr;
  assign pop        = rd_req & ~empty_q & last_slice & ~clr;
  assign count_nxt  = clr ? '0 : (count_q + CW'(push) - CW'(pop));
  assign hold_en_nxt = host_wr ? r_q_16data_i[1] : hold_en_q;

  assign head    = mem[rd_ptr_q];
  assign rd_word = empty_q ? status_word(overflow_q, full_q, empty_q, count_q)
                           : head[{slice_q, 4'b0000} +: 16];

  always_comb begin
    state_nxt = IDLE;
    case (state_q)
      IDLE:    state_nxt = rd_req ? RESP : IDLE;
      RESP:    state_nxt = rd_req ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (push) mem[wr_ptr_q] <= trace_i;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      slice_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      hold_q     <= 1'b0;
      hold_en_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      hold_en_q <= hold_en_nxt;
      count_q   <= count_nxt;
      full_q    <= (count_nxt == CW'(DEPTH));
      empty_q   <= (count_nxt == '0);
      hold_q    <= hold_en_nxt & (count_nxt >= CW'(DEPTH - 2));
      if (rd_req) rdata_q <= rd_word;
      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        slice_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (rd_req && !empty_q) slice_q <= last_slice ? '0 : slice_q + KW'(1);
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  assign r_variable_o = rdata_q;
  assign r_dv_trace_o = (state_q == RESP);
  assign fifo_empty_o = empty_q;
  assign fifo_full_o  = full_q;
  assign overflow_o   = overflow_q;
  assign hold_clk_o   = hold_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_a_trace_capture.sv
// Directed bench for a_trace_capture: read responses are checked against a queue
// of expected words filled when each read request is driven.
module tb_a_trace_capture;
  localparam int TRACE_W = 64;
  localparam int DEPTH   = 16;
  localparam int CW      = 5;

  logic               clk_ref = 1'b0;
  logic               rst_n;
  logic               run_verif_i, capt_trce_i;
  logic [TRACE_W-1:0] trace_i;
  logic               r_trace_sel_i, r_w_i, r_dv_i;
  logic [15:0]        r_q_16data_i;
  logic [15:0]        r_variable_o;
  logic               r_dv_trace_o, fifo_empty_o, fifo_full_o, overflow_o, hold_clk_o;
  logic [CW-1:0]      count_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];

  a_trace_capture #(.TRACE_W(TRACE_W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .run_verif_i(run_verif_i),
    .capt_trce_i(capt_trce_i), .trace_i(trace_i), .r_trace_sel_i(r_trace_sel_i),
    .r_w_i(r_w_i), .r_dv_i(r_dv_i), .r_q_16data_i(r_q_16data_i),
    .r_variable_o(r_variable_o), .r_dv_trace_o(r_dv_trace_o),
    .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .overflow_o(overflow_o),
    .hold_clk_o(hold_clk_o), .count_o(count_o)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_ref) begin
    if (r_dv_trace_o === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_dv", 64'(r_dv_trace_o), 64'd0);
      else chk("rdata", 64'(r_variable_o), 64'(sb.pop_front()));
    end
  end

  task automatic rd(input logic [15:0] exp);
    r_trace_sel_i = 1'b1; r_w_i = 1'b0; r_dv_i = 1'b1;
    sb.push_back(exp);
    @(negedge clk_ref);
    r_dv_i = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    r_trace_sel_i = 1'b1; r_w_i = 1'b1; r_dv_i = 1'b1; r_q_16data_i = d;
    @(negedge clk_ref);
    r_dv_i = 1'b0; r_w_i = 1'b0;
  endtask

  task automatic strobe(input logic [TRACE_W-1:0] d);
    capt_trce_i = 1'b1; trace_i = d;
    @(negedge clk_ref);
    capt_trce_i = 1'b0;
  endtask

  task automatic rd_entry(input logic [TRACE_W-1:0] d);
    for (int s = 0; s < TRACE_W / 16; s++) rd(d[16*s +: 16]);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rvar"}, 64'(r_variable_o), 64'd0);
    chk({pfx, "_rdv"}, 64'(r_dv_trace_o), 64'd0);
    chk({pfx, "_empty"}, 64'(fifo_empty_o), 64'd1);
    chk({pfx, "_full"}, 64'(fifo_full_o), 64'd0);
    chk({pfx, "_ovf"}, 64'(overflow_o), 64'd0);
    chk({pfx, "_hold"}, 64'(hold_clk_o), 64'd0);
    chk({pfx, "_count"}, 64'(count_o), 64'd0);
  endtask

  function automatic logic [TRACE_W-1:0] pat(input int i);
    return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
  endfunction

  initial begin
    rst_n = 1'b0; run_verif_i = 1'b0; capt_trce_i = 1'b0; trace_i = '0;
    r_trace_sel_i = 1'b0; r_w_i = 1'b0; r_dv_i = 1'b0; r_q_16data_i = '0;
    repeat (3) @(negedge clk_ref);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk_ref);

    // empty read returns status
    rd(16'h2000);

    // single capture, LSB slice first
    run_verif_i = 1'b1;
    strobe(64'h0123_4567_89AB_CDEF);
    chk("one_count", 64'(count_o), 64'd1);
    chk("one_empty", 64'(fifo_empty_o), 64'd0);
    rd(16'hCDEF); rd(16'h89AB); rd(16'h4567);
    chk("pre_pop_count", 64'(count_o), 64'd1);
    rd(16'h0123);
    chk("pop_count", 64'(count_o), 64'd0);
    rd(16'h2000);

    // fill with hold enabled, then overflow
    wr(16'h0002);
    for (int i = 0; i < DEPTH; i++) begin
      strobe(pat(i));
      chk("fill_count", 64'(count_o), 64'(i + 1));
      chk("fill_hold", 64'(hold_clk_o), 64'((i + 1) >= DEPTH - 2));
    end
    chk("full_flag", 64'(fifo_full_o), 64'd1);
    strobe(64'hDEAD_BEEF_DEAD_BEEF);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_count", 64'(count_o), 64'd16);
    for (int i = 0; i < DEPTH; i++) rd_entry(pat(i));
    chk("drain_empty", 64'(fifo_empty_o), 64'd1);
    rd(16'hA000);
    wr(16'h0001);
    chk("clr_ovf", 64'(overflow_o), 64'd0);

    // pop and capture in the same cycle
    strobe(pat(20)); strobe(pat(21)); strobe(pat(22));
    rd(16'hD014); rd(16'hC014); rd(16'hB014);
    capt_trce_i = 1'b1; trace_i = pat(23);
    rd(16'hA014);
    capt_trce_i = 1'b0;
    chk("popcap_count", 64'(count_o), 64'd3);
    rd_entry(pat(21));
    wr(16'h0001);

    // clear coincident with capture
    for (int i = 0; i < 5; i++) strobe(pat(30 + i));
    chk("five_count", 64'(count_o), 64'd5);
    capt_trce_i = 1'b1; trace_i = pat(40);
    wr(16'h0001);
    capt_trce_i = 1'b0;
    chk("clrcap_count", 64'(count_o), 64'd0);
    chk("clrcap_empty", 64'(fifo_empty_o), 64'd1);
    chk("clrcap_ovf", 64'(overflow_o), 64'd0);

    // strobes ignored outside a run
    run_verif_i = 1'b0;
    for (int i = 0; i < 3; i++) strobe(pat(50 + i));
    chk("norun_count", 64'(count_o), 64'd0);

    // reset before the response edge discards it
    r_trace_sel_i = 1'b1; r_w_i = 1'b0; r_dv_i = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk_ref);
    r_dv_i = 1'b0;
    chk_reset_vals("midrd");
    @(negedge clk_ref);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_ref);
    chk("post_rst_dv", 64'(r_dv_trace_o), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
